// File: rtl/gfp_proc_ab_mc_pkg.sv
// Shared op codes and helpers for the GF(p) pivot/elimination cell.
package gfp_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_PASS = 2'b00;
    localparam op_t OP_SWAP = 2'b01;
    localparam op_t OP_ELIM = 2'b10;
    localparam op_t OP_LOAD = 2'b11;

    // Column index width, never narrower than one bit.
    function automatic int unsigned cw_of(input int unsigned cols);
        return (cols <= 2) ? 1 : $clog2(cols);
    endfunction

endpackage

// File: rtl/gfp_proc_ab_mc_if.sv
// Beat bus of the GF(p) cell; master drives in_* and controls, slave returns out_*.
interface gfp_proc_ab_mc_if
    import gfp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned COLS  = 4
) ();
    localparam int unsigned CW = cw_of(COLS);

    logic             mode_a;
    logic             pass;
    logic             first_pass;
    logic             in_valid;
    logic [CW-1:0]    in_col;
    logic             in_start;
    logic             in_finish;
    op_t              in_op;
    logic [WIDTH-1:0] in_fac;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_inv;
    logic             in_inv_en;
    logic             in_clr;

    logic             out_valid;
    logic [CW-1:0]    out_col;
    logic             out_start;
    logic             out_finish;
    op_t              out_op;
    logic [WIDTH-1:0] out_fac;
    logic [WIDTH-1:0] out_data;
    logic             r_flag;

    modport master (
        output mode_a, pass, first_pass, in_valid, in_col, in_start, in_finish,
               in_op, in_fac, in_data, in_inv, in_inv_en, in_clr,
        input  out_valid, out_col, out_start, out_finish, out_op, out_fac,
               out_data, r_flag
    );

    modport slave (
        input  mode_a, pass, first_pass, in_valid, in_col, in_start, in_finish,
               in_op, in_fac, in_data, in_inv, in_inv_en, in_clr,
        output out_valid, out_col, out_start, out_finish, out_op, out_fac,
               out_data, r_flag
    );
endinterface

// File: rtl/gfp_proc_ab_mc_mad.sv
// Combinational multiply-add reduced modulo PRIME; product kept exact at 2*WIDTH bits.
module gfp_mad #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PRIME = 251
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_mad_c
);
    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] w_prod;
    logic [PW-1:0] w_sum;

    // Max a*b + c is (2^W-1)^2 + 2^W-1 < 2^(2W), so the sum cannot overflow.
    assign w_prod  = PW'(i_a) * PW'(i_b);
    assign w_sum   = w_prod + PW'(i_c);
    assign o_mad_c = WIDTH'(w_sum % PW'(PRIME));
endmodule

// File: rtl/gfp_proc_ab_mc.sv
// GF(p) Gaussian-elimination cell: pivot (A) or elimination (B), COLS time-multiplexed columns.
module gfp_proc_ab_mc
    import gfp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PRIME = 251,
    parameter int unsigned COLS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    gfp_proc_ab_mc_if.slave  bus
);
    localparam int unsigned CW = cw_of(COLS);

    logic [WIDTH-1:0] r_mem [COLS];

    logic             w_col_ok;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_mad_a;
    logic [WIDTH-1:0] w_mad_c;
    logic [WIDTH-1:0] w_mad;
    logic [WIDTH-1:0] w_out_data;
    logic [WIDTH-1:0] w_out_fac;
    op_t              w_out_op;
    logic [WIDTH-1:0] w_r_next;

    logic             r_out_valid;
    logic [CW-1:0]    r_out_col;
    logic             r_out_start;
    logic             r_out_finish;
    op_t              r_out_op;
    logic [WIDTH-1:0] r_out_fac;
    logic [WIDTH-1:0] r_out_data;
    logic             r_flag;

    assign w_col_ok = (32'(bus.in_col) < COLS);
    assign w_r      = w_col_ok ? r_mem[bus.in_col] : '0;

    gfp_mad #(.WIDTH(WIDTH), .PRIME(PRIME)) u_mad (
        .i_a     (w_mad_a),
        .i_b     (bus.in_fac),
        .i_c     (w_mad_c),
        .o_mad_c (w_mad)
    );

    // Beat datapath: operand muxing, output selection and stored-value update.
    always_comb begin
        w_mad_a    = w_r;
        w_mad_c    = bus.in_data;
        w_out_data = '0;
        w_out_fac  = bus.in_fac;
        w_out_op   = OP_PASS;
        w_r_next   = w_r;

        if (bus.in_op == OP_LOAD) begin
            w_mad_a = bus.in_data;
            w_mad_c = '0;
        end

        if (bus.pass)             w_out_data = bus.in_data;
        else if (bus.in_finish)   w_out_data = w_r;
        else if (bus.in_start)    w_out_data = '0;
        else if (bus.mode_a)      w_out_data = '0;
        else begin
            case (bus.in_op)
                OP_PASS: w_out_data = bus.in_data;
                OP_SWAP: w_out_data = w_r;
                OP_ELIM: w_out_data = w_mad;
                default: w_out_data = w_r;
            endcase
        end

        if (bus.mode_a) begin
            w_out_fac = w_r[0] ? bus.in_data : bus.in_inv;
            if (!w_r[0])
                w_r_next = (bus.in_inv_en && bus.first_pass) ? WIDTH'(1) : '0;
        end else begin
            if (bus.in_op == OP_SWAP)      w_r_next = bus.in_data;
            else if (bus.in_op == OP_LOAD) w_r_next = w_mad;
        end

        if (bus.pass)            w_out_op = OP_PASS;
        else if (!bus.mode_a)    w_out_op = bus.in_op;
        else if (bus.in_start)   w_out_op = bus.in_inv_en ? OP_LOAD : OP_SWAP;
        else if (bus.in_finish)  w_out_op = OP_SWAP;
        else if (!bus.in_inv_en) w_out_op = OP_PASS;
        else if (w_r[0])         w_out_op = OP_ELIM;
        else                     w_out_op = OP_LOAD;
    end

    // Column store; a clear beat wipes every entry and discards its own write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(COLS); i++) r_mem[i] <= '0;
        end else if (bus.in_valid) begin
            if (bus.in_clr) begin
                for (int i = 0; i < int'(COLS); i++) r_mem[i] <= '0;
            end else if (w_col_ok) begin
                r_mem[bus.in_col] <= w_r_next;
            end
        end
    end

    // Output stage: one-cycle beat latency, data holds between valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_col    <= '0;
            r_out_start  <= 1'b0;
            r_out_finish <= 1'b0;
            r_out_op     <= OP_PASS;
            r_out_fac    <= '0;
            r_out_data   <= '0;
            r_flag       <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out_col    <= bus.in_col;
                r_out_start  <= bus.in_start;
                r_out_finish <= bus.in_finish;
                r_out_op     <= w_out_op;
                r_out_fac    <= w_out_fac;
                r_out_data   <= w_out_data;
                r_flag       <= w_r_next[0] | bus.pass;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_col    = r_out_col;
    assign bus.out_start  = r_out_start;
    assign bus.out_finish = r_out_finish;
    assign bus.out_op     = r_out_op;
    assign bus.out_fac    = r_out_fac;
    assign bus.out_data   = r_out_data;
    assign bus.r_flag     = r_flag;
endmodule

// File: tb/tb_gfp_proc_ab_mc.sv
// Directed self-checking bench for gfp_proc_ab_mc at WIDTH=3, PRIME=7, COLS=4.
module tb_gfp_proc_ab_mc;
    import gfp_pkg::*;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned PRIME = 7;
    localparam int unsigned COLS  = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [2:0] rd_val;

    gfp_proc_ab_mc_if #(.WIDTH(WIDTH), .COLS(COLS)) bus ();

    gfp_proc_ab_mc #(.WIDTH(WIDTH), .PRIME(PRIME), .COLS(COLS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One valid beat driven at negedge; outputs are settled 1 time unit after the next posedge.
    task automatic beat(input logic ma, input logic ps, input logic fp, input logic clr,
                        input logic st, input logic fin, input logic inv_en,
                        input logic [1:0] col, input op_t op,
                        input logic [2:0] fac, input logic [2:0] data, input logic [2:0] inv);
        @(negedge clk);
        bus.mode_a     = ma;
        bus.pass       = ps;
        bus.first_pass = fp;
        bus.in_clr     = clr;
        bus.in_start   = st;
        bus.in_finish  = fin;
        bus.in_inv_en  = inv_en;
        bus.in_col     = col;
        bus.in_op      = op;
        bus.in_fac     = fac;
        bus.in_data    = data;
        bus.in_inv     = inv;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Non-destructive read: mode B finish beat with PASS returns r and leaves it unchanged.
    task automatic rd(input logic [1:0] col, output logic [2:0] d);
        beat(0, 0, 0, 0, 0, 1, 0, col, OP_PASS, 3'd0, 3'd0, 3'd0);
        d = bus.out_data;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.mode_a = 0; bus.pass = 0; bus.first_pass = 0; bus.in_valid = 0;
        bus.in_col = '0; bus.in_start = 0; bus.in_finish = 0; bus.in_op = OP_PASS;
        bus.in_fac = '0; bus.in_data = '0; bus.in_inv = '0; bus.in_inv_en = 0; bus.in_clr = 0;

        // Reset held with random inputs: every output stays zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mode_a = 1'($urandom); bus.pass = 1'($urandom); bus.first_pass = 1'($urandom);
            bus.in_valid = 1'b1; bus.in_col = 2'($urandom); bus.in_start = 1'($urandom);
            bus.in_finish = 1'($urandom); bus.in_op = 2'($urandom); bus.in_fac = 3'($urandom);
            bus.in_data = 3'($urandom); bus.in_inv = 3'($urandom); bus.in_inv_en = 1'($urandom);
            bus.in_clr = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_out_valid", 16'(bus.out_valid), 16'd0);
            check("rst_out_data", 16'(bus.out_data), 16'd0);
        end
        check("rst_out_fac", 16'(bus.out_fac), 16'd0);
        check("rst_out_op", 16'(bus.out_op), 16'd0);
        check("rst_r_flag", 16'(bus.r_flag), 16'd0);
        check("rst_out_col", 16'(bus.out_col), 16'd0);
        check("rst_out_start", 16'(bus.out_start), 16'd0);
        check("rst_out_finish", 16'(bus.out_finish), 16'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_clr   = 1'b0;
        rst_n        = 1'b1;

        for (int c = 0; c < 4; c++) begin
            rd(2'(c), rd_val);
            check("rst_r_zero", 16'(rd_val), 16'd0);
        end

        // Mode B swap then eliminate: 3*2+5 = 11 mod 7 = 4.
        beat(0, 0, 0, 0, 0, 0, 0, 2'd2, OP_SWAP, 3'd0, 3'd3, 3'd0);
        check("swap_out_data", 16'(bus.out_data), 16'd0);
        check("swap_out_valid", 16'(bus.out_valid), 16'd1);
        check("swap_out_col", 16'(bus.out_col), 16'd2);
        check("swap_out_op", 16'(bus.out_op), 16'(OP_SWAP));
        beat(0, 0, 0, 0, 0, 0, 0, 2'd2, OP_ELIM, 3'd2, 3'd5, 3'd0);
        check("elim_out_data", 16'(bus.out_data), 16'd4);
        check("elim_out_fac", 16'(bus.out_fac), 16'd2);
        rd(2'd2, rd_val);
        check("elim_r2_kept", 16'(rd_val), 16'd3);
        check("rd_out_finish", 16'(bus.out_finish), 16'd1);

        // Idle cycle: out_valid drops, data holds the last read value.
        idle();
        check("idle_out_valid", 16'(bus.out_valid), 16'd0);
        check("idle_out_data_hold", 16'(bus.out_data), 16'd3);

        // Mode B load: out = old r (2), r <= 4*5 mod 7 = 6.
        beat(0, 0, 0, 0, 0, 0, 0, 2'd1, OP_SWAP, 3'd0, 3'd2, 3'd0);
        beat(0, 0, 0, 0, 0, 0, 0, 2'd1, OP_LOAD, 3'd5, 3'd4, 3'd0);
        check("load_out_data", 16'(bus.out_data), 16'd2);
        check("load_out_op", 16'(bus.out_op), 16'(OP_LOAD));
        rd(2'd1, rd_val);
        check("load_r1", 16'(rd_val), 16'd6);

        // Mode A pivot on col0: first beat latches pivot, second eliminates.
        beat(1, 0, 1, 0, 0, 0, 1, 2'd0, OP_PASS, 3'd0, 3'd3, 3'd5);
        check("pivA1_out_op", 16'(bus.out_op), 16'(OP_LOAD));
        check("pivA1_out_fac", 16'(bus.out_fac), 16'd5);
        check("pivA1_r_flag", 16'(bus.r_flag), 16'd1);
        check("pivA1_out_data", 16'(bus.out_data), 16'd0);
        beat(1, 0, 1, 0, 0, 0, 1, 2'd0, OP_PASS, 3'd0, 3'd3, 3'd5);
        check("pivA2_out_op", 16'(bus.out_op), 16'(OP_ELIM));
        check("pivA2_out_fac", 16'(bus.out_fac), 16'd3);
        rd(2'd0, rd_val);
        check("pivA_r0", 16'(rd_val), 16'd1);

        // Mode A start without inverse: op SWAP, no pivot latched.
        beat(1, 0, 1, 0, 1, 0, 0, 2'd3, OP_PASS, 3'd0, 3'd0, 3'd0);
        check("startA_out_op", 16'(bus.out_op), 16'(OP_SWAP));
        check("startA_r_flag", 16'(bus.r_flag), 16'd0);
        check("startA_out_start", 16'(bus.out_start), 16'd1);

        // Bypass overrides ELIM.
        beat(0, 1, 0, 0, 0, 0, 0, 2'd2, OP_ELIM, 3'd1, 3'd6, 3'd0);
        check("pass_out_data", 16'(bus.out_data), 16'd6);
        check("pass_out_op", 16'(bus.out_op), 16'(OP_PASS));
        check("pass_r_flag", 16'(bus.r_flag), 16'd1);
        rd(2'd2, rd_val);
        check("pass_r2_kept", 16'(rd_val), 16'd3);

        // Clear collides with a write: output from pre-clear r, all entries zero after.
        beat(0, 0, 0, 0, 0, 0, 0, 2'd3, OP_SWAP, 3'd0, 3'd2, 3'd0);
        beat(0, 0, 0, 1, 0, 0, 0, 2'd3, OP_SWAP, 3'd0, 3'd5, 3'd0);
        check("clr_out_data", 16'(bus.out_data), 16'd2);
        for (int c = 0; c < 4; c++) begin
            rd(2'(c), rd_val);
            check("clr_r_zero", 16'(rd_val), 16'd0);
        end
        beat(0, 0, 0, 0, 0, 0, 0, 2'd3, OP_SWAP, 3'd0, 3'd1, 3'd0);
        check("b2b_swap1", 16'(bus.out_data), 16'd0);
        beat(0, 0, 0, 0, 0, 0, 0, 2'd3, OP_SWAP, 3'd0, 3'd4, 3'd0);
        check("b2b_swap2", 16'(bus.out_data), 16'd1);

        // Product exceeds WIDTH bits: 4*6+6 = 30 mod 7 = 2.
        beat(0, 0, 0, 0, 0, 0, 0, 2'd3, OP_ELIM, 3'd6, 3'd6, 3'd0);
        check("elim_wide_prod", 16'(bus.out_data), 16'd2);

        // Mid-stream reset drops the in-flight beat and its write.
        @(negedge clk);
        bus.mode_a = 0; bus.pass = 0; bus.in_clr = 0; bus.in_start = 0; bus.in_finish = 0;
        bus.in_col = 2'd0; bus.in_op = OP_SWAP; bus.in_data = 3'd5; bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_data", 16'(bus.out_data), 16'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_out_valid", 16'(bus.out_valid), 16'd0);
        rd(2'd0, rd_val);
        check("midrst_r0", 16'(rd_val), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
